// File: rtl/brm_pkg.sv
// Shared definitions for the binary rate multiplier.
// Optional feature macro: BRM_PCNT_EN (per-period pulse counter on the top).
package brm_pkg;

  // Widest counter/rate the multiplier supports.
  localparam int BRM_MAX_W = 32;

  // Rate-load handshake state: IDLE accepts a new rate, PEND holds one until wrap.
  typedef enum logic {
    HS_IDLE = 1'b0,
    HS_PEND = 1'b1
  } hs_state_t;

  // Number of consecutive ones starting at bit 0, looking at the low w bits only.
  // A value of w means the low w bits are all ones.
  function automatic int trailing_ones(input logic [BRM_MAX_W-1:0] vec, input int w);
    int   n;
    logic run;
    n   = 0;
    run = 1'b1;
    for (int i = 0; i < BRM_MAX_W; i++) begin
      if (i < w && run && vec[i]) begin
        n = n + 1;
      end else begin
        run = 1'b0;
      end
    end
    return n;
  endfunction

endpackage

// File: rtl/brm_stage_sel.sv
// Stage selector: maps the counter value to a one-hot stage vector.
// Stage k fires when the counter has exactly k trailing ones; the all-ones
// counter value fires no stage and instead raises the wrap flag.
module brm_stage_sel
  import brm_pkg::*;
#(
  parameter int W = 16
) (
  input  logic [W-1:0] cnt,
  output logic [W-1:0] fire,
  output logic         wrap
);

  logic [BRM_MAX_W-1:0] cnt_ext;
  int                   k;

  assign cnt_ext = BRM_MAX_W'(cnt);

  // Decode trailing-ones count into a one-hot fire vector (empty on wrap).
  always_comb begin
    fire = '0;
    wrap = &cnt;
    k    = trailing_ones(cnt_ext, W);
    for (int i = 0; i < W; i++) begin
      fire[i] = !wrap && (k == i);
    end
  end

endmodule

// File: rtl/brm_rate_mult.sv
// Synchronous binary rate multiplier with registered Z/TC outputs and a
// valid/ready rate-load port whose new rate takes effect only at a period wrap.
// Handshake: a rate is transferred on a rising CK edge where RATE_VLD and
// RATE_RDY are both high; RATE_RDY is low while a loaded rate is still pending.
// Optional feature macro: BRM_PCNT_EN adds the PCNT port (pulses in last period).
module brm_rate_mult
  import brm_pkg::*;
#(
  parameter int          W        = 16,
  parameter int unsigned RST_RATE = 0
) (
  input  logic         CK,
  input  logic         RST,
  input  logic         EN,
  input  logic [W-1:0] RATE,
  input  logic         RATE_VLD,
  output logic         RATE_RDY,
  output logic         Z,
  output logic         TC,
  output logic [W-1:0] CNT
`ifdef BRM_PCNT_EN
 ,output logic [W-1:0] PCNT
`endif
);

  logic [W-1:0] cnt;
  logic [W-1:0] rate_act;
  logic [W-1:0] rate_pend;
  logic [W-1:0] rate_rev;
  logic [W-1:0] fire;
  hs_state_t    hs;
  logic         wrap;
  logic         z_q;
  logic         tc_q;
  logic         z_next;
  logic         accept;
  logic         wrap_step;

  brm_stage_sel #(.W(W)) u_stage_sel (
    .cnt  (cnt),
    .fire (fire),
    .wrap (wrap)
  );

  // Rate MSB feeds stage 0 (every second step), LSB feeds the last stage.
  always_comb begin
    rate_rev = '0;
    for (int i = 0; i < W; i++) begin
      rate_rev[i] = rate_act[W-1-i];
    end
  end

  assign z_next    = !wrap && (|(fire & rate_rev));
  assign accept    = RATE_VLD && (hs == HS_IDLE);
  assign wrap_step = EN && wrap;

  // Counter, registered outputs and rate-load handshake state.
  always_ff @(posedge CK) begin
    if (RST) begin
      cnt       <= '0;
      rate_act  <= W'(RST_RATE);
      rate_pend <= '0;
      hs        <= HS_IDLE;
      z_q       <= 1'b0;
      tc_q      <= 1'b0;
    end else begin
      if (EN) begin
        cnt  <= cnt + W'(1);
        z_q  <= z_next;
        tc_q <= wrap;
      end else begin
        z_q  <= 1'b0;
        tc_q <= 1'b0;
      end
      if (wrap_step) begin
        // Period boundary: the only point where the active rate may change.
        if (hs == HS_PEND) begin
          rate_act <= rate_pend;
          hs       <= HS_IDLE;
        end else if (accept) begin
          rate_act <= RATE;
        end
      end else if (accept) begin
        rate_pend <= RATE;
        hs        <= HS_PEND;
      end
    end
  end

  assign RATE_RDY = (hs == HS_IDLE);
  assign Z        = z_q;
  assign TC       = tc_q;
  assign CNT      = cnt;

`ifdef BRM_PCNT_EN
  logic [W-1:0] pcnt_acc;
  logic [W-1:0] pcnt_q;

  // Count Z pulses within the period; publish the total when the counter wraps.
  always_ff @(posedge CK) begin
    if (RST) begin
      pcnt_acc <= '0;
      pcnt_q   <= '0;
    end else if (EN) begin
      if (wrap) begin
        pcnt_q   <= pcnt_acc + W'(z_next);
        pcnt_acc <= '0;
      end else begin
        pcnt_acc <= pcnt_acc + W'(z_next);
      end
    end
  end

  assign PCNT = pcnt_q;
`endif

endmodule
